// File: rtl/seq_param_bank_pkg.sv
// Purpose: shared types and constants for the double-buffered generator parameter bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_param_bank_pkg;

    localparam int DEF_NUM_CH = 64;
    localparam int DEF_DW     = 16;
    localparam int DEF_TW     = 16;

    // Field select encoding on wr_sel; value 3 is reserved and ignored.
    localparam logic [1:0] SEL_AMP    = 2'd0;
    localparam logic [1:0] SEL_OFFSET = 2'd1;
    localparam logic [1:0] SEL_PHASE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/param_shadow_bank.sv
// Purpose: one field (amp, offset or phaseword) of the bank: indexed shadow write, copy to active on swap.
// Latency: shadow write and active copy both take effect at the clock edge they are requested on.
// Backpressure: none; writes and swaps are always accepted.
module param_shadow_bank
    import seq_param_bank_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DW     = DEF_DW,
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [DW-1:0]        wr_data,
    input  logic                 swap,
    output logic [NUM_CH*DW-1:0] active
);

    logic [DW-1:0] shadow   [NUM_CH];
    logic [DW-1:0] active_r [NUM_CH];

    // Shadow takes host writes; on swap the active copy samples the shadow as it
    // stood before this edge, so a same-cycle write lands only in the shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k]   <= '0;
                active_r[k] <= '0;
            end
        end else begin
            if (swap) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    active_r[k] <= shadow[k];
                end
            end
            if (wr_en) begin
                shadow[wr_idx] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign active[k*DW +: DW] = active_r[k];
    end

endmodule

// File: rtl/seq_param_bank.sv
// Purpose: double-buffered parameter bank with swap, duration countdown and finished pulse; SEQ_PARAM_BANK_LOOP_EN enables auto-restart.
// Latency: swap copies at the triggering edge; gen_reset/finished are registered one-cycle pulses.
// Backpressure: none; host strobes are always accepted, writes past the last channel are dropped and flagged.
module seq_param_bank
    import seq_param_bank_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int TW     = DEF_TW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [1:0]           wr_sel,
    input  logic [DW-1:0]        wr_data,
    input  logic                 addr_clr,
    input  logic [TW-1:0]        dur_in,
    input  logic                 arm,
    input  logic                 force_swap,
    output logic [NUM_CH*DW-1:0] active_amps,
    output logic [NUM_CH*DW-1:0] active_offsets,
    output logic [NUM_CH*DW-1:0] active_phasewords,
    output logic                 gen_reset,
    output logic                 gen_active,
    output logic                 finished,
    output logic [TW-1:0]        cur_time,
    output logic [6:0]           ch_ptr,
    output logic                 overflow
);

    localparam int         IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [6:0] CH_LIMIT = 7'(NUM_CH);

`ifdef SEQ_PARAM_BANK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] cur_time_nxt;
    logic [TW-1:0] dur_shadow;
    logic          armed;
    logic          swap;
    logic          restart;
    logic          fin_nxt;

    // addr_clr outranks a same-cycle write; reserved select is ignored entirely.
    logic wr_field;
    logic ch_ok;
    logic wr_do;
    assign wr_field = wr_en && !addr_clr && (wr_sel != 2'd3);
    assign ch_ok    = (ch_ptr < CH_LIMIT);
    assign wr_do    = wr_field && ch_ok;

    // Next state, countdown and pulse requests; a swap always wins over the countdown.
    always_comb begin
        state_nxt    = state;
        cur_time_nxt = cur_time;
        fin_nxt      = 1'b0;
        swap         = force_swap || (armed && (state == DONE));
        restart      = LOOP_EN && (state == DONE) && !swap;
        gen_active   = (state == RUN);
        if (swap || restart) begin
            state_nxt    = RUN;
            cur_time_nxt = dur_shadow;
        end else if (state == RUN) begin
            if (cur_time == '0) begin
                state_nxt = DONE;
                fin_nxt   = 1'b1;
            end else begin
                cur_time_nxt = cur_time - 1'b1;
            end
        end
    end

    // State register, countdown and registered one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_time  <= '0;
            finished  <= 1'b0;
            gen_reset <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_time  <= cur_time_nxt;
            finished  <= fin_nxt;
            gen_reset <= swap || restart;
        end
    end

    // Arm flag: consumed by any swap, even one coinciding with a new arm strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (swap) begin
            armed <= 1'b0;
        end else if (arm) begin
            armed <= 1'b1;
        end
    end

    // Channel pointer, overflow flag and duration shadow; pointer advances after
    // the phaseword so each channel is filled amp, offset, phaseword.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_ptr     <= '0;
            overflow   <= 1'b0;
            dur_shadow <= '0;
        end else if (addr_clr) begin
            ch_ptr     <= '0;
            overflow   <= 1'b0;
            dur_shadow <= dur_in;
        end else if (wr_field) begin
            if (!ch_ok) begin
                overflow <= 1'b1;
            end else if (wr_sel == SEL_PHASE) begin
                ch_ptr <= ch_ptr + 7'd1;
            end
        end
    end

    param_shadow_bank #(.NUM_CH(NUM_CH), .DW(DW)) u_amp_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_do && (wr_sel == SEL_AMP)),
        .wr_idx  (ch_ptr[IW-1:0]),
        .wr_data (wr_data),
        .swap    (swap),
        .active  (active_amps)
    );

    param_shadow_bank #(.NUM_CH(NUM_CH), .DW(DW)) u_offset_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_do && (wr_sel == SEL_OFFSET)),
        .wr_idx  (ch_ptr[IW-1:0]),
        .wr_data (wr_data),
        .swap    (swap),
        .active  (active_offsets)
    );

    param_shadow_bank #(.NUM_CH(NUM_CH), .DW(DW)) u_phase_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_do && (wr_sel == SEL_PHASE)),
        .wr_idx  (ch_ptr[IW-1:0]),
        .wr_data (wr_data),
        .swap    (swap),
        .active  (active_phasewords)
    );

endmodule
